// File: rtl/rr_arbiter83.sv
// rr_arbiter83: eight-way round-robin arbiter with a 3-bit owner index.
// A grant is held until the owner signals done or drops its request.
// After each release there is at least one idle cycle. Priority then
// rotates to the requester after the last owner.
//
// Optional feature macro: RR_ARB83_TIMEOUT_EN
//   When defined, a grant is forced released after HOLD_MAX cycles, and
//   oTimeout pulses in the cycle where oValid falls.
//   When undefined, no hold counter is built, oTimeout is tied low and
//   HOLD_MAX has no effect.
//
// Handshake: the arbiter is a level-sensitive request/grant scheme, not a
// valid/ready stream. A requester holds iReq[n] high until it is served.
// oValid/oGrant/oIdx present the current owner. A release takes effect at
// the next clock edge after iDone=1 or iReq[oIdx]=0 is seen while oValid=1.
module rr_arbiter83 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iReq,
  input  logic       iDone,
  output logic [7:0] oGrant,
  output logic [2:0] oIdx,
  output logic       oValid,
  output logic       oTimeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state, state_next;
  logic [2:0] ptr, ptr_next;
  logic [7:0] grant_q, grant_next;
  logic [2:0] idx_q, idx_next;
  logic       valid_q, valid_next;
  logic       tmo_q, tmo_next;

  logic       sel_found;
  logic [2:0] sel;
  logic       tmo_hit;
  logic       release_now;

`ifdef RR_ARB83_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // Hold counter: it sits at zero while idle, so it starts from zero on
  // every new grant. It then counts each cycle that the grant is held.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      hold_cnt <= 8'd0;
    end else if (state == GRANT) begin
      hold_cnt <= hold_cnt + 8'd1;
    end else begin
      hold_cnt <= 8'd0;
    end
  end

  // Release on the edge that ends the HOLD_MAX-th held cycle.
  assign tmo_hit = (state == GRANT) && (hold_cnt == 8'(HOLD_MAX - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // Circular ascending search for the first request, starting at ptr.
  always_comb begin
    sel_found = 1'b0;
    sel       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] j;
      j = ptr + 3'(i);
      if (!sel_found && iReq[j]) begin
        sel_found = 1'b1;
        sel       = j;
      end
    end
  end

  assign release_now = iDone || !iReq[idx_q] || tmo_hit;

  // Next-state and next-output logic. Every output is registered from
  // these signals.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    grant_next = grant_q;
    idx_next   = idx_q;
    valid_next = valid_q;
    tmo_next   = 1'b0;
    case (state)
      IDLE: begin
        if (sel_found) begin
          state_next = GRANT;
          idx_next   = sel;
          grant_next = 8'b1 << sel;
          valid_next = 1'b1;
          ptr_next   = sel + 3'd1;
        end
      end
      GRANT: begin
        // Requests from other requesters never preempt the current grant.
        // oIdx and ptr are left unchanged when the grant is released.
        if (release_now) begin
          state_next = IDLE;
          grant_next = 8'h00;
          valid_next = 1'b0;
          tmo_next   = tmo_hit;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 8'h00;
        valid_next = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      grant_q <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      grant_q <= grant_next;
      idx_q   <= idx_next;
      valid_q <= valid_next;
      tmo_q   <= tmo_next;
    end
  end

  assign oGrant   = grant_q;
  assign oIdx     = idx_q;
  assign oValid   = valid_q;
  assign oTimeout = tmo_q;

endmodule
